// File: rtl/fp_mul_collect_pkg.sv
// Class flag definitions shared by the half-precision multiplier and its collector.
package fp_mul_collect_pkg;

  localparam int unsigned NTYPES = 6;

  localparam int unsigned SNAN      = 0;
  localparam int unsigned QNAN      = 1;
  localparam int unsigned INFINITY  = 2;
  localparam int unsigned ZERO      = 3;
  localparam int unsigned SUBNORMAL = 4;
  localparam int unsigned NORMAL    = 5;

endpackage

// File: rtl/fp_mul_collect_fp_sync_fifo.sv
// Synchronous valid/ready FIFO with occupancy output; storage is not reset.
module fp_sync_fifo #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W-1:0]               in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               out_data,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic          push, pop;

  // Handshake derives only from registered occupancy, so a pop never frees a slot same-cycle.
  assign in_ready  = (level_q != LW'(DEPTH));
  assign out_valid = (level_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem_q[rd_q] : '0;
  assign level     = level_q;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    if (push) wr_d = wr_q + AW'(1);
    if (pop)  rd_d = rd_q + AW'(1);
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= in_data;
  end

endmodule

// File: rtl/fp_mul_collect.sv
// Registers multiplier products into a FIFO and keeps sticky class status and a NaN counter.
// Define FP_COLLECT_FTZ_EN to flush subnormal products to signed zero on capture.
module fp_mul_collect
  import fp_mul_collect_pkg::*;
#(
  parameter int unsigned NEXP  = 5,
  parameter int unsigned NSIG  = 10,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNTW  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NEXP+NSIG:0]       in_p,
  input  logic [NTYPES-1:0]        in_flags,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NEXP+NSIG:0]       out_p,
  output logic [NTYPES-1:0]        out_flags,
  input  logic                     clr_sticky,
  output logic [NTYPES-1:0]        sticky_flags,
  output logic [CNTW-1:0]          nan_count,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PW = NEXP + NSIG + 1;
  localparam int unsigned EW = PW + NTYPES;

  logic [PW-1:0]     st_p;
  logic [NTYPES-1:0] st_f;
  logic [NTYPES-1:0] sticky_q, sticky_d;
  logic [CNTW-1:0]   nan_q, nan_d;
  logic              push, nan_hit;
  logic [EW-1:0]     head;

  always_comb begin
    st_p = in_p;
    st_f = in_flags;
`ifdef FP_COLLECT_FTZ_EN
    if (in_flags[SUBNORMAL]) begin
      st_p       = {in_p[PW-1], {(PW-1){1'b0}}};
      st_f       = '0;
      st_f[ZERO] = 1'b1;
    end
`endif
  end

  fp_sync_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({st_p, st_f}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head),
    .level     (level)
  );

  assign out_p     = head[EW-1:NTYPES];
  assign out_flags = head[NTYPES-1:0];

  assign push    = in_valid && in_ready;
  assign nan_hit = st_f[SNAN] || st_f[QNAN];

  // Clear applies first, then the coinciding push contributes.
  always_comb begin
    sticky_d = clr_sticky ? '0 : sticky_q;
    nan_d    = clr_sticky ? '0 : nan_q;
    if (push) begin
      sticky_d = sticky_d | st_f;
      if (nan_hit && (nan_d != '1)) nan_d = nan_d + CNTW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= '0;
      nan_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      nan_q    <= nan_d;
    end
  end

  assign sticky_flags = sticky_q;
  assign nan_count    = nan_q;

endmodule

// File: doc/fp_mul_collect.md
Name: fp_mul_collect

Overview:
- Downstream stage of the combinational half-precision multiplier (fp_mul). Captures each product and its class flags into a small FIFO, then streams them to the motion pipeline over a valid/ready handshake.
- Keeps sticky exception status and a saturating NaN-event counter for the control/status interface.
- Breaks the long combinational multiply path with a registered boundary.

Parameters:
- NEXP, 5, exponent width of the product word.
- NSIG, 10, stored significand width; product word is NEXP+NSIG+1 bits.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNTW, 8, width of the NaN event counter.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  product/flags from the multiplier are valid this cycle.
- in_ready  out  1  FIFO can accept a product (not full).
- in_p  in  NEXP+NSIG+1  product word from the multiplier.
- in_flags  in  NTYPES  one-hot class flags (SNAN, QNAN, INFINITY, ZERO, SUBNORMAL, NORMAL).
- out_valid  out  1  head entry valid (not empty).
- out_ready  in  1  consumer accepts the head entry.
- out_p  out  NEXP+NSIG+1  head product.
- out_flags  out  NTYPES  head flags.
- clr_sticky  in  1  synchronous clear of sticky_flags and nan_count.
- sticky_flags  out  NTYPES  OR of the flags of all accepted products since the last clear.
- nan_count  out  CNTW  count of accepted products with SNAN or QNAN set; saturates at all-ones.
- level  out  log2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async, rst=1): write pointer, read pointer and level = 0; in_ready=1, out_valid=0; sticky_flags=0; nan_count=0. out_p and out_flags read as 0 while empty. Storage array is not reset.
- Push when in_valid && in_ready; pop when out_valid && out_ready. Both are evaluated on the same clk edge.
- Latency: a product pushed at edge N is visible on out_p/out_flags with out_valid=1 after edge N. No fall-through while empty.
- Outputs come combinationally from the head entry; out_p and out_flags are held stable while out_valid && !out_ready.
- Pointers are log2(DEPTH) bits and wrap naturally. level is a separate counter: +1 on push only, -1 on pop only, unchanged on push and pop together.
- Full (level==DEPTH): in_ready=0. A simultaneous pop does not enable a push in the same cycle; in_ready depends only on registered state.
- Empty (level==0): out_valid=0. A push and a pop cannot both occur.
- Full with a pop: level becomes DEPTH-1 and in_ready rises on the next cycle.
- in_valid while !in_ready: data is dropped, and neither sticky_flags nor nan_count update. Upstream must hold the data.
- Sticky/counter updates occur only on an accepted push, using the flags as stored. Flag effect: sticky_flags |= flags. NaN effect: nan_count += 1 if flags[SNAN] or flags[QNAN], saturating at 2^CNTW-1.
- clr_sticky priority: a clear coinciding with an accepted push yields sticky_flags = that push's flags and nan_count = 0 or 1 (clear first, then that push's contribution). The clear does not touch the FIFO.
- in_flags is not checked for one-hot correctness; it is stored verbatim.
- Reset asserted mid-stream discards all entries immediately; no partial state survives.

Optional Feature:
- Macro FP_COLLECT_FTZ_EN.
- Defined: on push, a product flagged SUBNORMAL is stored as signed zero ({sign, all zeros}) with flags = ZERO only. Sticky and counter logic see the modified flags.
- Undefined: subnormals are stored and reported unchanged.

Decomposition:
- Shared package/include (the existing flags include) supplies NTYPES and the flag bit indices SNAN, QNAN, INFINITY, ZERO, SUBNORMAL, NORMAL; no new constants are needed there.
- One natural sub-module, fp_sync_fifo: parameterised width and depth, valid/ready FIFO with a level output.
- Top level adds the FTZ substitution, sticky register and saturating counter.

Test Plan:
- Reset then push 0x3C00/NORMAL, out_ready=1 -> out_valid rises the cycle after the push, out_p=0x3C00, level returns to 0 after the pop.
- Push 4 products with out_ready=0 -> level=4, in_ready=0; a 5th in_valid with 0x4000 is not accepted; pop all 4 -> exact order, no 0x4000.
- Full FIFO with push and pop in the same cycle -> only the pop happens, level=3, in_ready=1 next cycle.
- Push 0x7E00/QNAN, 0x7C01/SNAN, 0x7C00/INFINITY -> sticky_flags has QNAN|SNAN|INFINITY, nan_count=2; clr_sticky together with a NORMAL push -> sticky_flags=NORMAL, nan_count=0.
- Push 2^CNTW+3 QNAN products while draining -> nan_count stays at 255 (CNTW=8).
- FP_COLLECT_FTZ_EN defined: push 0x8001/SUBNORMAL -> out_p=0x8000, out_flags=ZERO. Undefined -> out_p=0x8001, out_flags=SUBNORMAL.
- Assert rst with 3 entries queued -> out_valid=0, level=0, sticky_flags=0 immediately (asynchronous).
